// File: rtl/uart_apb_pkg.sv
// Shared FSM state type and UART register map for the APB master and its users.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [4:0] ADDR_DR   = 5'd0;
  localparam logic [4:0] ADDR_IER  = 5'd1;
  localparam logic [4:0] ADDR_IIR  = 5'd2;
  localparam logic [4:0] ADDR_FCR  = 5'd2;
  localparam logic [4:0] ADDR_LCR  = 5'd3;
  localparam logic [4:0] ADDR_MCR  = 5'd4;
  localparam logic [4:0] ADDR_LSR  = 5'd5;
  localparam logic [4:0] ADDR_MSR  = 5'd6;
  localparam logic [4:0] ADDR_DIV1 = 5'd7;
  localparam logic [4:0] ADDR_DIV2 = 5'd8;

endpackage

// File: rtl/uart_apb_master.sv
// One command -> one APB transfer -> one response; at least 4 cycles per transfer.
// cmd_ready only in IDLE; the response is held until rsp_ready, ACCESS aborts after TIMEOUT waits.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [4:0]        paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // Abort on the wait that brings the count to TIMEOUT, i.e. after TIMEOUT ACCESS cycles.
          if ((TIMEOUT != 0) && (cnt_inc == TMO)) begin
            state_d       = RESP;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = 32'd0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Bench for uart_apb_master: directed table, corner sequences and randomized transfers.
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  uart_apb_master #(.TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    int          wt;    // PREADY comes on ACCESS cycle wt+1
    logic [31:0] prd;
    logic        serr;
    int          hold;  // cycles rsp_ready stays low once rsp_valid is seen
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          psel_cyc;
    int          lat;     // cycles from accept cycle to first rsp_valid cycle
  } exp_t;

  typedef struct {
    cmd_t c;
    exp_t e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_g    = 0;
  int last_acc = 0;
  int issued   = 0;
  logic [37:0] setups[$];

  always @(posedge PCLK) cyc_g <= cyc_g + 1;

  always @(negedge PCLK)
    if (!PRESET && PSEL && !PENABLE) setups.push_back({PWRITE, PADDR, PWDATA});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t model(input cmd_t c);
    exp_t e;
    int acc;
    if (c.wt >= TMO) begin
      acc = TMO; e.rdata = 32'd0; e.err = 1'b1; e.to = 1'b1;
    end else begin
      acc = c.wt + 1; e.rdata = c.w ? 32'd0 : c.prd; e.err = c.serr; e.to = 1'b0;
    end
    e.psel_cyc = 1 + acc;
    e.lat      = 2 + acc;
    return e;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic run_xfer(input cmd_t c, input string tag, output exp_t got, output logic ok);
    int cyc, acc_n, held;
    logic done;
    logic [33:0] cap;
    got = '{32'd0, 1'b0, 1'b0, 0, -1};
    ok = 1'b1; done = 1'b0; acc_n = 0; held = 0; cap = '0;
    cmd_valid = 1'b1; cmd_write = c.w; cmd_addr = c.a; cmd_wdata = c.d;
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    last_acc = cyc_g;
    issued++;
    tick();
    cyc = 1;
    while (!done && cyc < 400) begin
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 5'($urandom); cmd_wdata = $urandom;
      if (cmd_ready) ok = 1'b0;
      if (PSEL) begin
        got.psel_cyc++;
        if (PADDR !== c.a || PWDATA !== c.d || PWRITE !== c.w) ok = 1'b0;
        if (PENABLE !== (got.psel_cyc > 1)) ok = 1'b0;
      end else if (PENABLE) ok = 1'b0;
      PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      if (PSEL && PENABLE) begin
        acc_n++;
        PREADY = (acc_n == c.wt + 1);
        if (PREADY) begin PRDATA = c.prd; PSLVERR = c.serr; end
      end
      if (rsp_valid) begin
        if (got.lat < 0) begin
          got.lat = cyc; got.rdata = rsp_rdata; got.err = rsp_err; got.to = rsp_timeout;
          cap = {rsp_rdata, rsp_err, rsp_timeout};
        end else if ({rsp_rdata, rsp_err, rsp_timeout} !== cap) ok = 1'b0;
        if (held == c.hold) begin rsp_ready = 1'b1; done = 1'b1; end
        else begin rsp_ready = 1'b0; held++; end
      end
      tick();
      cyc++;
    end
    rsp_ready = 1'b0; cmd_valid = 1'b0; PREADY = 1'b0;
    chk({tag, ".rsp_within_bound"}, 32'(done), 32'd1);
    chk({tag, ".post_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".post_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic compare(input string tag, input exp_t got, input exp_t e, input logic ok);
    chk({tag, ".rdata"}, got.rdata, e.rdata);
    chk({tag, ".err"}, 32'(got.err), 32'(e.err));
    chk({tag, ".timeout"}, 32'(got.to), 32'(e.to));
    chk({tag, ".psel_cycles"}, got.psel_cyc, e.psel_cyc);
    chk({tag, ".rsp_latency"}, got.lat, e.lat);
    chk({tag, ".protocol"}, 32'(ok), 32'd1);
  endtask

  initial begin
    vec_t tbl[7];
    cmd_t c;
    exp_t got;
    logic ok;
    int acc1, base;
    logic quiet;

    tbl[0] = '{'{1'b1, ADDR_LCR,  32'h0000_0083, 1,   32'h0,         1'b0, 0}, '{32'h0,         1'b0, 1'b0, 3,  4}};
    tbl[1] = '{'{1'b0, ADDR_DIV1, 32'h0,         0,   32'h0000_0045, 1'b0, 0}, '{32'h0000_0045, 1'b0, 1'b0, 2,  3}};
    tbl[2] = '{'{1'b0, 5'h1F,     32'h0,         0,   32'hDEAD_BEEF, 1'b1, 1}, '{32'hDEAD_BEEF, 1'b1, 1'b0, 2,  3}};
    tbl[3] = '{'{1'b0, ADDR_LSR,  32'h0,         255, 32'h0000_0060, 1'b1, 0}, '{32'h0,         1'b1, 1'b1, 17, 18}};
    tbl[4] = '{'{1'b0, ADDR_MSR,  32'h0,         15,  32'h0000_1234, 1'b0, 0}, '{32'h0000_1234, 1'b0, 1'b0, 17, 18}};
    tbl[5] = '{'{1'b1, ADDR_FCR,  32'h0000_00C7, 2,   32'h0000_0099, 1'b1, 5}, '{32'h0,         1'b1, 1'b0, 4,  5}};
    tbl[6] = '{'{1'b1, ADDR_MCR,  32'h0000_0003, 16,  32'h0,         1'b0, 2}, '{32'h0,         1'b1, 1'b1, 17, 18}};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    @(negedge PCLK);
    repeat (3) tick();
    chk("reset.ctl", 32'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    chk("reset.paddr", 32'(PADDR), 32'd0);
    chk("reset.pwdata", PWDATA, 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    PRESET = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i].c, $sformatf("vec%0d", i), got, ok);
      compare($sformatf("vec%0d", i), got, tbl[i].e, ok);
    end

    // Back-to-back writes: second command accepted exactly one transfer period later
    base = setups.size();
    c = '{1'b1, ADDR_IER, 32'h0000_000F, 0, 32'h0, 1'b0, 0};
    run_xfer(c, "b2b_ier", got, ok);
    compare("b2b_ier", got, '{32'h0, 1'b0, 1'b0, 2, 3}, ok);
    acc1 = last_acc;
    c = '{1'b1, ADDR_MCR, 32'h0000_0010, 0, 32'h0, 1'b0, 0};
    run_xfer(c, "b2b_mcr", got, ok);
    compare("b2b_mcr", got, '{32'h0, 1'b0, 1'b0, 2, 3}, ok);
    chk("b2b.accept_spacing", last_acc - acc1, 32'd4);
    chk("b2b.first_setup", 32'(setups[base]), 32'({1'b1, ADDR_IER, 32'h0000_000F}));
    chk("b2b.second_setup", 32'(setups[base + 1]), 32'({1'b1, ADDR_MCR, 32'h0000_0010}));
    chk("b2b.first_setup_hi", 32'(setups[base] >> 32), 32'({1'b1, ADDR_IER}));
    chk("b2b.second_setup_hi", 32'(setups[base + 1] >> 32), 32'({1'b1, ADDR_MCR}));

    // Reset while the slave is stalling in ACCESS
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = ADDR_DIV2; cmd_wdata = 32'h0000_0055;
    issued++;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("midrst.in_access", 32'({PSEL, PENABLE}), 32'd3);
    PRESET = 1'b1;
    tick();
    chk("midrst.ctl", 32'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 32'd0);
    chk("midrst.pwdata", PWDATA, 32'd0);
    PRESET = 1'b0;
    tick();
    chk("midrst.cmd_ready", 32'(cmd_ready), 32'd1);
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid || PSEL) quiet = 1'b0;
      tick();
    end
    chk("midrst.no_response", 32'(quiet), 32'd1);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      c.w    = 1'($urandom);
      c.a    = 5'($urandom);
      c.d    = $urandom;
      c.prd  = $urandom;
      c.serr = 1'($urandom);
      c.hold = $urandom_range(0, 3);
      c.wt   = (r < 5) ? r : (r < 7) ? $urandom_range(5, 14) : (r == 7) ? 15 : (r == 8) ? 16 : 30;
      run_xfer(c, $sformatf("rnd%0d", n), got, ok);
      compare($sformatf("rnd%0d", n), got, model(c), ok);
    end

    chk("apb_transfer_count", setups.size(), issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum ACCESS-phase cycles without PREADY before abort; 0 disables the timeout.
REQ-002 SHALL have port PCLK  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port PRESET  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
REQ-006 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  in  5  register address.
REQ-008 SHALL have port cmd_wdata  in  32  write data.
REQ-009 SHALL have port rsp_valid  out  1  response available.
REQ-010 SHALL have port rsp_ready  in  1  response consumed.
REQ-011 SHALL have port rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-012 SHALL have port rsp_err  out  1  PSLVERR captured, or timeout.
REQ-013 SHALL have port rsp_timeout  out  1  transfer aborted by timeout.
REQ-014 SHALL have APB ports PSEL, PENABLE, PWRITE (out, 1 bit each), PADDR (out, 5 bits) and PWDATA (out, 32 bits).
REQ-015 SHALL have APB ports PRDATA (in, 32 bits), PREADY (in, 1 bit) and PSLVERR (in, 1 bit).

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP; every output SHALL be registered, except cmd_ready, which is decoded from the state.
REQ-017 SHALL drive cmd_ready = 1 only in IDLE; cmd_valid & cmd_ready at edge N latches write/addr/wdata and enters SETUP.
REQ-018 In SETUP (cycle N+1): PSEL=1, PENABLE=0, with PADDR, PWRITE and PWDATA driven from the latched command; the next state is unconditionally ACCESS.
REQ-019 In ACCESS: PSEL=1 and PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP until PSEL falls.
REQ-020 When PREADY=1 is sampled in ACCESS, the block SHALL capture rsp_rdata (PRDATA if read, else 0) and rsp_err=PSLVERR, set rsp_timeout=0, drop PSEL and PENABLE, and enter RESP; rsp_valid rises on the next cycle.
REQ-021 A wait counter SHALL clear on SETUP->ACCESS and increment on each ACCESS cycle with PREADY=0; its width is clog2(TIMEOUT+1) and it saturates, never wraps.
REQ-022 When the counter equals TIMEOUT (TIMEOUT>0) with PREADY=0, the block SHALL drop PSEL and PENABLE, set rsp_err=1, rsp_timeout=1 and rsp_rdata=0, and enter RESP.
REQ-023 If PREADY=1 arrives in the same cycle the timeout would fire, PREADY SHALL win as a normal completion.
REQ-024 In RESP: rsp_valid=1, and the rsp_* outputs SHALL be held until rsp_ready=1, then the FSM returns to IDLE; no new command is accepted in that same cycle.
REQ-025 Minimum transfer period SHALL be 4 cycles (IDLE, SETUP, ACCESS with immediate PREADY, RESP with rsp_ready=1).
REQ-026 PSLVERR and PRDATA SHALL be ignored outside an ACCESS cycle with PREADY=1.
REQ-027 cmd_* changes while not in IDLE SHALL have no effect.

Reset
REQ-028 PRESET=1 SHALL force IDLE with PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0 and the counter at 0.
REQ-029 Reset mid-transfer SHALL abort it with no response issued; cmd_ready SHALL be 1 in the first cycle after PRESET deasserts.

Structure
REQ-030 The state enum (IDLE/SETUP/ACCESS/RESP) and the UART register address constants (DR=0, IER=1, IIR/FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, DIV1=7, DIV2=8) SHALL live in the shared package uart_apb_pkg.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Write LCR: cmd write addr 3, data 0x0000_0083, slave PREADY one cycle after PENABLE -> PSEL high 3 cycles, PWDATA=0x83 stable, rsp_err=0, rsp_rdata=0.
REQ-033 Read DIV1: slave returns PRDATA=0x0000_0045 with zero wait -> rsp_rdata=0x45, rsp_valid 3 cycles after command accept.
REQ-034 Read addr 0x1F with slave PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-035 TIMEOUT=16, PREADY held 0 -> PSEL drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; a PREADY arriving exactly on cycle 16 -> normal completion.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout; PRESET asserted during ACCESS -> PSEL=0 and rsp_valid=0 next cycle.
REQ-037 Back-to-back writes to IER=0x0F then MCR=0x10 with rsp_ready=1 -> two APB transfers separated by one idle cycle, in command order.
